// File: rtl/uart_tx_arbiter_if.sv
// Request bundle for the two-source UART transmitter.
// master: drives valid/data, samples ready; slave: the arbiter.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_data,
        output req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data,
        input  req1_valid, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin two-requester UART transmitter (8 data bits, LSB first).
// Ports: clk, rstn (async low), req (slave bundle), tx_o, busy_o, grant_id_o.
// Optional even parity bit when UART_PARITY_EN is defined.
module uart_tx_arbiter #(
    parameter int CLK_DIV = 2083,
    parameter int DIV_W   = 12
) (
    input  logic  clk,
    input  logic  rstn,
    uart_tx_arbiter_if.slave req,
    output logic  tx_o,
    output logic  busy_o,
    output logic  grant_id_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             ptr_q, ptr_d;
    logic             grant_q, grant_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
`ifdef UART_PARITY_EN
    logic             par_q, par_d;
`endif

    logic eob;
    logic win0, win1;
    logic acc0, acc1;

    // ptr_q holds the last granted source; on contention the other wins.
    assign win0 = req.req0_valid & (~req.req1_valid | ptr_q);
    assign win1 = req.req1_valid & (~req.req0_valid | ~ptr_q);

    assign req.req0_ready = (state_q == IDLE) & win0;
    assign req.req1_ready = (state_q == IDLE) & win1;

    assign acc0 = req.req0_valid & req.req0_ready;
    assign acc1 = req.req1_valid & req.req1_ready;

    assign eob = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (eob) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                bit_d = '0;
                if (acc0) begin
                    shift_d = req.req0_data;
                    grant_d = 1'b0;
                    ptr_d   = 1'b0;
                    state_d = START;
`ifdef UART_PARITY_EN
                    par_d   = ^req.req0_data;
`endif
                end else if (acc1) begin
                    shift_d = req.req1_data;
                    grant_d = 1'b1;
                    ptr_d   = 1'b1;
                    state_d = START;
`ifdef UART_PARITY_EN
                    par_d   = ^req.req1_data;
`endif
                end
            end
            START: begin
                if (eob) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (eob) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (eob) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (eob) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is registered from the next state so tx_o
        // always matches the bit the FSM is currently in.
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ptr_q   <= 1'b1;
            grant_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (CLK_DIV=4 and default divider).
// Honours UART_PARITY_EN for frame expectations.
module tb_uart_tx_arbiter;

`ifdef UART_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    localparam int DIVB = 2083;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if ifa();
    uart_tx_arbiter_if ifb();

    logic txa, busya, gida;
    logic txb, busyb, gidb;

    uart_tx_arbiter #(.CLK_DIV(4), .DIV_W(12)) dut_a (
        .clk        (clk),
        .rstn       (rstn),
        .req        (ifa.slave),
        .tx_o       (txa),
        .busy_o     (busya),
        .grant_id_o (gida)
    );

    uart_tx_arbiter dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .req        (ifb.slave),
        .tx_o       (txb),
        .busy_o     (busyb),
        .grant_id_o (gidb)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (FL == 11 && i == 9) return ^d;
        return 1'b1;
    endfunction

    // Starts at the accept edge + 1; ends on the negedge of the idle cycle.
    task automatic watch_a(input string tag, input logic [7:0] d,
                           input logic g);
        for (int k = 1; k <= FL * 4; k++) begin
            @(negedge clk);
            chk($sformatf("%s.tx%0d", tag, k), txa, fbit(d, (k - 1) / 4));
            if (k == 1) begin
                chk({tag, ".busy_hi"}, busya, 1'b1);
                chk({tag, ".grant"}, gida, g);
            end
        end
        @(negedge clk);
        chk({tag, ".busy_lo"}, busya, 1'b0);
        chk({tag, ".idle_tx"}, txa, 1'b1);
    endtask

    task automatic wait_ready_a(output int n);
        n = 0;
        #1;
        while (!(ifa.req0_ready | ifa.req1_ready) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", 1, 0);
    endtask

    initial begin
        int n, low, total;
        logic g;
        logic first;
        ifa.req0_valid = 0; ifa.req0_data = 0;
        ifa.req1_valid = 0; ifa.req1_data = 0;
        ifb.req0_valid = 0; ifb.req0_data = 0;
        ifb.req1_valid = 0; ifb.req1_data = 0;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst.tx", txa, 1'b1);
        chk("rst.busy", busya, 1'b0);
        chk("rst.grant", gida, 1'b0);
        chk("rst.rdy0", ifa.req0_ready, 1'b0);
        chk("rst.rdy1", ifa.req1_ready, 1'b0);

        // single byte from requester 0
        @(posedge clk); #1;
        ifa.req0_valid = 1; ifa.req0_data = 8'hA5;
        @(negedge clk);
        chk("a5.rdy0", ifa.req0_ready, 1'b1);
        chk("a5.rdy1", ifa.req1_ready, 1'b0);
        @(posedge clk); #1;
        ifa.req0_valid = 0;
        watch_a("a5", 8'hA5, 1'b0);

        // requester 1 alone, back to back
        ifa.req1_valid = 1; ifa.req1_data = 8'h3C;
        #1;
        chk("r1.rdy1", ifa.req1_ready, 1'b1);
        @(posedge clk); #1;
        ifa.req1_data = 8'hC3;
        watch_a("3c", 8'h3C, 1'b1);
        #1;
        chk("r1.b2b", ifa.req1_ready, 1'b1);
        @(posedge clk); #1;
        ifa.req1_valid = 0;
        watch_a("c3", 8'hC3, 1'b1);

        // contention: strict alternation starting with 0
        ifa.req0_valid = 1; ifa.req0_data = 8'h11;
        ifa.req1_valid = 1; ifa.req1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            wait_ready_a(n);
            if (i > 0) chk($sformatf("rr%0d.gap", i), n, 0);
            chk($sformatf("rr%0d.excl", i),
                ifa.req0_ready & ifa.req1_ready, 1'b0);
            chk($sformatf("rr%0d.order", i), ifa.req1_ready, i % 2);
            g = ifa.req1_ready;
            @(posedge clk); #1;
            if (i == 3) begin
                ifa.req0_valid = 0;
                ifa.req1_valid = 0;
            end
            watch_a($sformatf("rr%0d", i), g ? 8'h22 : 8'h11, g);
        end

        // reset in the middle of a frame
        ifa.req0_valid = 1; ifa.req0_data = 8'h5A;
        #1;
        chk("mid.rdy0", ifa.req0_ready, 1'b1);
        @(posedge clk); #1;
        ifa.req0_valid = 0;
        repeat (16) @(posedge clk);
        #2;
        chk("mid.busy_before", busya, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid.tx", txa, 1'b1);
        chk("mid.busy", busya, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ifa.req0_valid = 1; ifa.req0_data = 8'h81;
        ifa.req1_valid = 1; ifa.req1_data = 8'h42;
        #1;
        chk("post.rdy0", ifa.req0_ready, 1'b1);
        chk("post.rdy1", ifa.req1_ready, 1'b0);
        @(posedge clk); #1;
        ifa.req0_valid = 0;
        ifa.req1_valid = 0;
        watch_a("post", 8'h81, 1'b0);

        // parity-relevant byte (odd weight)
        ifa.req0_valid = 1; ifa.req0_data = 8'h07;
        @(posedge clk); #1;
        ifa.req0_valid = 0;
        watch_a("p07", 8'h07, 1'b0);

        // default divider, byte 0x00
        @(posedge clk); #1;
        ifb.req0_valid = 1; ifb.req0_data = 8'h00;
        @(negedge clk);
        chk("b.rdy0", ifb.req0_ready, 1'b1);
        @(posedge clk); #1;
        ifb.req0_valid = 0;
        low = 0; total = 0; first = 1'b1;
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            if (!busyb) break;
            total++;
            if (!txb && first) low++;
            if (txb) first = 1'b0;
        end
        chk("b.total", total, FL * DIVB);
        chk("b.lowrun", low, (FL == 11 ? 10 : 9) * DIVB);
        chk("b.idle_tx", txb, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
